// File: rtl/transceive.sv
// 8N1 UART transceiver: independent receiver (with a one-byte holding register) and transmitter.
// Optional TRANSCEIVE_RX_SYNC_EN adds a 2-flop synchronizer on rxd.
module transceive #(
    parameter real BAUDRATE  = 9600.0,
    parameter real FREQUENCY = 12e6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    input  logic       rx_rdy,
    output logic       txd,
    input  logic [7:0] tx_dat,
    input  logic       tx_stb,
    output logic       tx_rdy
);
    localparam int CYCLES = $rtoi(FREQUENCY / BAUDRATE);
    localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] FULL = CW'(CYCLES - 1);
    localparam logic [CW-1:0] HALF = CW'(CYCLES / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic rx_in;
`ifdef TRANSCEIVE_RX_SYNC_EN
    logic [1:0] rx_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], rxd};
    end
    assign rx_in = rx_sync[1];
`else
    assign rx_in = rxd;
`endif

    // ---------------- receiver ----------------
    state_t          rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_bit, rx_bit_n;
    logic [7:0]      rx_sh, rx_sh_n;
    logic            rx_err, rx_err_n;
    logic            rx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_err   <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            rx_err   <= rx_err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_err_n   = rx_err;
        rx_done    = 1'b0;
        case (rx_state)
            IDLE: if (!rx_in) begin
                rx_state_n = START;
                rx_cnt_n   = '0;
            end
            START: if (rx_cnt == HALF) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_in ? IDLE : DATA;
            end else rx_cnt_n = rx_cnt + 1'b1;
            DATA: if (rx_cnt == FULL) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_in, rx_sh[7:1]};
                if (rx_bit == 3'd7) rx_state_n = STOP;
                else                rx_bit_n   = rx_bit + 1'b1;
            end else rx_cnt_n = rx_cnt + 1'b1;
            STOP: begin
                // framing error parks here until the line returns high
                if (rx_err) begin
                    if (rx_in) begin
                        rx_state_n = IDLE;
                        rx_err_n   = 1'b0;
                    end
                end else if (rx_cnt == FULL) begin
                    rx_cnt_n = '0;
                    if (rx_in) begin
                        rx_state_n = IDLE;
                        rx_done    = 1'b1;
                    end else rx_err_n = 1'b1;
                end else rx_cnt_n = rx_cnt + 1'b1;
            end
            default: rx_state_n = IDLE;
        endcase
    end

    // holding register: a byte completing while one is still held is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_dat <= 8'h00;
            rx_stb <= 1'b0;
        end else if (rx_done && (!rx_stb || rx_rdy)) begin
            rx_dat <= rx_sh;
            rx_stb <= 1'b1;
        end else if (rx_stb && rx_rdy) begin
            rx_stb <= 1'b0;
        end
    end

    // ---------------- transmitter ----------------
    state_t          tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_bit, tx_bit_n;
    logic [7:0]      tx_sh, tx_sh_n;
    logic            txd_n;

    assign tx_rdy = (tx_state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            txd      <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        txd_n      = txd;
        case (tx_state)
            IDLE: if (tx_stb) begin
                tx_state_n = START;
                tx_sh_n    = tx_dat;
                tx_cnt_n   = '0;
                txd_n      = 1'b0;
            end
            START: if (tx_cnt == FULL) begin
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                txd_n      = tx_sh[0];
                tx_sh_n    = {1'b1, tx_sh[7:1]};
                tx_state_n = DATA;
            end else tx_cnt_n = tx_cnt + 1'b1;
            DATA: if (tx_cnt == FULL) begin
                tx_cnt_n = '0;
                if (tx_bit == 3'd7) begin
                    tx_state_n = STOP;
                    txd_n      = 1'b1;
                end else begin
                    tx_bit_n = tx_bit + 1'b1;
                    txd_n    = tx_sh[0];
                    tx_sh_n  = {1'b1, tx_sh[7:1]};
                end
            end else tx_cnt_n = tx_cnt + 1'b1;
            STOP: if (tx_cnt == FULL) begin
                tx_cnt_n   = '0;
                tx_state_n = IDLE;
            end else tx_cnt_n = tx_cnt + 1'b1;
            default: tx_state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_transceive.sv
// Scoreboard bench for transceive: stimulus pushes expected bytes, rx/tx monitors pop and compare.
module tb_transceive;
    localparam int C = 16;

    logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1;
    logic       txd, rx_stb, tx_stb, rx_rdy, tx_rdy;
    logic [7:0] rx_dat, tx_dat;
    logic       loop = 1'b0, rrdy = 1'b0, tstb = 1'b0, mon_en = 1'b1;
    logic [7:0] tdat = 8'h00;
    logic [7:0] txb;
    int         checks = 0, errors = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] lb_bytes [3] = '{8'h8f, 8'hf8, 8'h77};

    always #5 clk = ~clk;

    assign tx_dat = loop ? rx_dat : tdat;
    assign tx_stb = loop ? rx_stb : tstb;
    assign rx_rdy = loop ? tx_rdy : rrdy;

    transceive #(.BAUDRATE(1.0e6), .FREQUENCY(16.0e6)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_rdy(rx_rdy),
        .txd(txd), .tx_dat(tx_dat), .tx_stb(tx_stb), .tx_rdy(tx_rdy)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stopb);
        rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) tick();
        end
        rxd = stopb;
        repeat (C) tick();
        rxd = 1'b1;
    endtask

    task automatic wait_q(input string name, input int budget);
        int n = 0;
        while ((rxq.size() != 0 || txq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 8'(rxq.size() + txq.size()), 8'd0);
    endtask

    // rx monitor: a handshake is seen the half-cycle before the accepting edge
    always @(negedge clk) begin
        if (!rst && rx_stb && rx_rdy) begin
            if (rxq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected got %h want none", rx_dat);
            end else chk("rx_byte", rx_dat, rxq.pop_front());
        end
    end

    // tx monitor: samples each bit near its centre
    initial forever begin
        @(negedge clk);
        if (mon_en && !rst && txd == 1'b0) begin
            repeat (C/2 - 1) @(negedge clk);
            chk("tx_start", 8'(txd), 8'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(negedge clk);
                txb[i] = txd;
            end
            repeat (C) @(negedge clk);
            chk("tx_stop", 8'(txd), 8'd1);
            if (txq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected got %h want none", txb);
            end else chk("tx_byte", txb, txq.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_txd", 8'(txd), 8'd1);
        chk("rst_tx_rdy", 8'(tx_rdy), 8'd1);
        chk("rst_rx_stb", 8'(rx_stb), 8'd0);
        chk("rst_rx_dat", rx_dat, 8'h00);
        rst = 1'b0;
        repeat (2) tick();

        // loopback echo
        loop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxq.push_back(lb_bytes[i]);
            txq.push_back(lb_bytes[i]);
            send(lb_bytes[i], 1'b1);
            repeat (2*C) tick();
        end
        wait_q("loopback_drain", 30*C);
        repeat (C) tick();
        loop = 1'b0;

        // overrun: second back-to-back byte dropped, first held
        rrdy = 1'b0;
        rxq.push_back(8'h55);
        send(8'h55, 1'b1);
        send(8'haa, 1'b1);
        repeat (4) tick();
        chk("ovr_stb", 8'(rx_stb), 8'd1);
        chk("ovr_dat", rx_dat, 8'h55);
        rrdy = 1'b1;
        tick();
        rrdy = 1'b0;
        tick();
        chk("ovr_clr", 8'(rx_stb), 8'd0);
        wait_q("ovr_drain", 2);

        // false start glitch
        rrdy = 1'b1;
        rxd = 1'b0;
        repeat (C/4) tick();
        rxd = 1'b1;
        repeat (2*C) tick();
        chk("false_start", 8'(rx_stb), 8'd0);
        rxq.push_back(8'h3c);
        send(8'h3c, 1'b1);
        wait_q("glitch_recv", 4*C);

        // framing error: byte discarded
        send(8'ha5, 1'b0);
        repeat (2*C) tick();
        chk("frame_err", 8'(rx_stb), 8'd0);
        rxq.push_back(8'h5a);
        send(8'h5a, 1'b1);
        wait_q("frame_recv", 4*C);

        // single tx byte with exact busy duration
        txq.push_back(8'h01);
        tdat = 8'h01;
        tstb = 1'b1;
        chk("tx_rdy_pre", 8'(tx_rdy), 8'd1);
        tick();
        tstb = 1'b0;
        chk("tx_busy", 8'(tx_rdy), 8'd0);
        repeat (10*C - 1) tick();
        chk("tx_rdy_late", 8'(tx_rdy), 8'd0);
        tick();
        chk("tx_rdy_back", 8'(tx_rdy), 8'd1);
        wait_q("tx01_drain", 2*C);

        // reset in the middle of a data bit
        mon_en = 1'b0;
        tdat = 8'h00;
        tstb = 1'b1;
        tick();
        tstb = 1'b0;
        repeat (C + 4*C + C/2) tick();
        chk("mid_txd_low", 8'(txd), 8'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_txd", 8'(txd), 8'd1);
        chk("arst_tx_rdy", 8'(tx_rdy), 8'd1);
        tick();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        txq.push_back(8'hc3);
        tdat = 8'hc3;
        tstb = 1'b1;
        tick();
        tstb = 1'b0;
        wait_q("post_rst_tx", 12*C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
